fetch_issue: RTL and testbench

FETCH_ISSUE -- requirements
Module: fetch_issue

---
 rtl/fetch_issue_pkg.sv | 19 +
 rtl/fetch_issue.sv | 102 ++++++++++
 tb/tb_fetch_issue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_issue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_issue_pkg
//   Shared pipeline definitions for the fetch stage and its neighbours:
//     NOP_INSN     - canonical no-op encoding (addi x0, x0, 0)
//     PC_INCREMENT - byte step between sequential fetch addresses
//     fetch_state_t - fetch FSM state encodings
// ---------------------------------------------------------------------------
package fetch_issue_pkg;

  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
  localparam int unsigned PC_INCREMENT = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_issue.sv
// ---------------------------------------------------------------------------
// fetch_issue
//   Instruction fetch request generator. Walks the PC in 4-byte steps,
//   presents one request per cycle to instruction memory and reports which
//   PC's data is returning one cycle after each accepted request.
//
// Handshake: a request is offered whenever i_mem_read=1; it is accepted in
//   any cycle where i_mem_read=1 and i_mem_ready=1. While offered but not
//   accepted, i_mem_read_address holds its value. i_mem_read is combinational
//   from state, stall and redirect and never depends on i_mem_ready.
//
// Ports:
//   clock              - sole clock, rising edge
//   reset              - synchronous, active-low
//   stall              - downstream hold; no request offered
//   redirect           - taken branch/jump/trap; kill fetch, load target_PC
//   target_PC          - redirect destination
//   i_mem_ready        - memory accepts the offered request this cycle
//   i_mem_read         - request valid
//   i_mem_read_address - request address (registered PC)
//   issue_PC           - PC of the instruction whose data returns this cycle
//   issue_valid        - issue_PC and returned data are live
//   fetch_count        - number of accepted requests (wraps)
//   scan               - debug-scan enable; qualifies scan_hit for monitors
// ---------------------------------------------------------------------------
module fetch_issue
  import fetch_issue_pkg::*;
#(
  parameter int unsigned                ADDRESS_BITS    = 32,
  parameter logic [ADDRESS_BITS-1:0]    RESET_PC        = '0,
  parameter int unsigned                SCAN_CYCLES_MIN = 0,
  parameter int unsigned                SCAN_CYCLES_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  input  logic                    i_mem_ready,
  output logic                    i_mem_read,
  output logic [ADDRESS_BITS-1:0] i_mem_read_address,
  output logic [ADDRESS_BITS-1:0] issue_PC,
  output logic                    issue_valid,
  output logic [31:0]             fetch_count,
  input  logic                    scan
);

  localparam logic [ADDRESS_BITS-1:0] PC_STEP = ADDRESS_BITS'(PC_INCREMENT);

  fetch_state_t            state;
  fetch_state_t            state_next;
  logic [ADDRESS_BITS-1:0] pc;
  logic [31:0]             fetch_count_q;
  logic                    accept;
  logic                    scan_hit;

  // Redirect suppresses the request so a killed address is never accepted.
  assign i_mem_read         = (state != BOOT) && !stall && !redirect;
  assign accept             = i_mem_read && i_mem_ready;
  assign i_mem_read_address = pc;
  assign fetch_count        = fetch_count_q;

  // Debug-scan window, sampled by simulation monitors only. Written as an
  // offset compare so a zero lower bound needs no special case.
  assign scan_hit = scan &&
    ((fetch_count_q - 32'(SCAN_CYCLES_MIN)) <= 32'(SCAN_CYCLES_MAX - SCAN_CYCLES_MIN));

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = ISSUE;
      ISSUE:   if (stall || (i_mem_read && !i_mem_ready)) state_next = HOLD;
      HOLD:    if (accept) state_next = ISSUE;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      issue_PC      <= '0;
      issue_valid   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        pc <= target_PC;
      end else if (accept) begin
        pc <= pc + PC_STEP;
      end
      // accept is already 0 under redirect, so the cycle after a redirect
      // never reports a live issue.
      issue_valid <= accept;
      if (accept) begin
        issue_PC      <= pc;
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_issue.sv
module tb_fetch_issue;
  import fetch_issue_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] target_PC;
  logic        i_mem_ready;
  logic        i_mem_read;
  logic [31:0] i_mem_read_address;
  logic [31:0] issue_PC;
  logic        issue_valid;
  logic [31:0] fetch_count;
  logic        scan;

  always #5 clock = ~clock;

  fetch_issue #(
    .ADDRESS_BITS   (32),
    .RESET_PC       (32'h0),
    .SCAN_CYCLES_MIN(0),
    .SCAN_CYCLES_MAX(1000)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .stall             (stall),
    .redirect          (redirect),
    .target_PC         (target_PC),
    .i_mem_ready       (i_mem_ready),
    .i_mem_read        (i_mem_read),
    .i_mem_read_address(i_mem_read_address),
    .issue_PC          (issue_PC),
    .issue_valid       (issue_valid),
    .fetch_count       (fetch_count),
    .scan              (scan)
  );

  // Debug-scan print, driven by the DUT's scan window qualifier.
  always @(posedge clock) begin
    if (dut.scan_hit)
      $display("[SCAN] state=%s pc=%h issue_pc=%h", dut.state.name(), dut.pc, dut.issue_PC);
  end

  // ---------------- reference model ----------------
  // Abstract view: a fetch pointer, a one-entry "returning" slot and a count.
  int          tests  = 0;
  int          failed = 0;
  bit          m_started;
  logic [31:0] m_pc;
  logic [31:0] m_issue_pc;
  logic        m_issue_valid;
  logic [31:0] m_count;

  task automatic model_reset();
    m_started     = 1'b0;
    m_pc          = 32'h0;
    m_issue_pc    = 32'h0;
    m_issue_valid = 1'b0;
    m_count       = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs at the falling edge, check, then advance
  // the model across the rising edge. Returns at the next falling edge.
  task automatic cycle(input logic rst_n, input logic st, input logic rd,
                       input logic [31:0] tgt, input logic rdy);
    logic exp_read;
    logic acc;
    reset       = rst_n;
    stall       = st;
    redirect    = rd;
    target_PC   = tgt;
    i_mem_ready = rdy;
    #1;
    exp_read = m_started && !st && !rd;
    check("i_mem_read", 32'(i_mem_read), 32'(exp_read));
    if (exp_read) check("i_mem_read_address", i_mem_read_address, m_pc);
    check("issue_valid", 32'(issue_valid), 32'(m_issue_valid));
    if (m_issue_valid) check("issue_PC", issue_PC, m_issue_pc);
    check("fetch_count", fetch_count, m_count);
    @(posedge clock);
    if (!rst_n) begin
      model_reset();
    end else begin
      acc           = exp_read && rdy;
      m_issue_valid = acc;
      if (acc) begin
        m_issue_pc = m_pc;
        m_count    = m_count + 32'd1;
      end
      if (rd)       m_pc = tgt;
      else if (acc) m_pc = m_pc + 32'd4;
      m_started = 1'b1;
    end
    @(negedge clock);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; target_PC = '0;
    i_mem_ready = 1'b0; scan = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    model_reset();

    // Reset state
    check("rst_state", 32'(dut.state), 32'(BOOT));
    check("rst_issue_valid", 32'(issue_valid), 32'h0);
    check("rst_issue_pc", issue_PC, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_read", 32'(i_mem_read), 32'h0);

    // Release with ready held: idle BOOT cycle then 0x0, 0x4, then 0x8 stalls
    scan = 1'b1;
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    scan = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0);
      check("hold_addr", i_mem_read_address, 32'h8);
      check("hold_issue_valid", 32'(issue_valid), 32'h0);
    end
    cycle(1, 0, 0, 0, 1);
    check("hold_release_pc", issue_PC, 32'h8);
    check("hold_release_valid", 32'(issue_valid), 32'h1);

    // Redirect during streaming
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 1, 32'h100, 1);
    check("redir_addr", i_mem_read_address, 32'h100);
    check("redir_issue_valid", 32'(issue_valid), 32'h0);
    cycle(1, 0, 0, 0, 1);

    // Redirect together with stall, stall held two more cycles
    cycle(1, 1, 1, 32'h200, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    check("redir_stall_pc", issue_PC, 32'h200);

    // fetch_count wrap
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    m_count = 32'hFFFF_FFFF;
    cycle(1, 0, 0, 0, 1);
    check("count_wrap", fetch_count, 32'h0);

    // PC wrap
    cycle(1, 0, 1, 32'hFFFF_FFFC, 1);
    cycle(1, 0, 0, 0, 1);
    check("pc_wrap_issue", issue_PC, 32'hFFFF_FFFC);
    check("pc_wrap_next", i_mem_read_address, 32'h0);

    // Reset while holding at 0x40
    cycle(1, 0, 1, 32'h40, 1);
    cycle(1, 1, 0, 0, 1);
    check("hold40_state", 32'(dut.state), 32'(HOLD));
    cycle(0, 0, 0, 0, 1);
    check("midrst_state", 32'(dut.state), 32'(BOOT));
    check("midrst_addr", i_mem_read_address, 32'h0);
    check("midrst_issue_pc", issue_PC, 32'h0);
    check("midrst_issue_valid", 32'(issue_valid), 32'h0);
    check("midrst_count", fetch_count, 32'h0);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    check("midrst_first_issue", issue_PC, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic        r_rst;
      logic        r_st;
      logic        r_rd;
      logic        r_rdy;
      logic [31:0] r_tgt;
      r_rst = ($urandom_range(0, 63) != 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_rd  = ($urandom_range(0, 9) == 0);
      r_rdy = ($urandom_range(0, 9) < 7);
      r_tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      cycle(r_rst, r_st, r_rd, r_tgt, r_rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
